// File: rtl/riscv_csr_access_unit.sv
// ---------------------------------------------------------------------------
// riscv_csr_access_unit
//
// Initiator side of the CSR register-file port. Decoded CSR/system requests
// from the execute stage are turned into sequenced address / write-data /
// write-enable cycles on a CSR file that has one combinational read port and
// one synchronous write port. It returns the old CSR value for rd on CSR ops,
// or a redirect PC for ECALL (mtvec) and MRET (mepc).
//
// Sequences:
//   RW/RS/RC : IDLE -> READ -> WRITE -> RESP
//   ECALL    : IDLE -> EPC -> CAUSE -> VEC -> RESP
//   MRET     : IDLE -> VEC -> RESP
//   NONE/bad : IDLE -> RESP
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready only in IDLE)
//   req_op              0 NONE, 1 RW, 2 RS, 3 RC, 4 ECALL, 5 MRET, else illegal
//   req_addr            12-bit CSR address
//   req_src             rs1 value or zero-extended zimm
//   req_src_is_x0       rs1/zimm index is zero
//   req_pc              PC of the instruction
//   csr_addr/csr_wdata  CSR file address (zero-extended) and write data
//   csr_we              CSR file write strobe, one cycle per write
//   csr_rdata           CSR file combinational read data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           old CSR value on CSR ops, 0 otherwise
//   rsp_redirect/rsp_pc redirect target for ECALL/MRET
//   rsp_illegal         illegal request
//
// Optional feature macro: CSR_RO_CHECK_EN
//   When defined, a CSR op that would write into the read-only space
//   (addr[11:10] == 2'b11) still reads, suppresses the write and reports
//   rsp_illegal with the old value. When undefined, no address check is done.
// ---------------------------------------------------------------------------
module riscv_csr_access_unit #(
    parameter int          WORD_LENGTH = 32,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter int          ECALL_CAUSE = 11
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [11:0]            req_addr,
    input  logic [WORD_LENGTH-1:0] req_src,
    input  logic                   req_src_is_x0,
    input  logic [WORD_LENGTH-1:0] req_pc,
    output logic [WORD_LENGTH-1:0] csr_addr,
    output logic [WORD_LENGTH-1:0] csr_wdata,
    output logic                   csr_we,
    input  logic [WORD_LENGTH-1:0] csr_rdata,
    output logic                   rsp_valid,
    output logic [WORD_LENGTH-1:0] rsp_rdata,
    output logic                   rsp_redirect,
    output logic [WORD_LENGTH-1:0] rsp_pc,
    output logic                   rsp_illegal
);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_RW    = 3'd1;
    localparam logic [2:0] OP_RS    = 3'd2;
    localparam logic [2:0] OP_RC    = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_EPC,
        ST_CAUSE,
        ST_VEC,
        ST_RESP
    } state_t;

    function automatic logic [WORD_LENGTH-1:0] zext_addr(input logic [11:0] a);
        zext_addr = {{(WORD_LENGTH-12){1'b0}}, a};
    endfunction

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [11:0]            addr_q, addr_d;
    logic [WORD_LENGTH-1:0] src_q, src_d;
    logic                   src_is_x0_q, src_is_x0_d;
    logic [WORD_LENGTH-1:0] old_q, old_d;
    logic [WORD_LENGTH-1:0] csr_addr_q, csr_addr_d;
    logic [WORD_LENGTH-1:0] csr_wdata_q, csr_wdata_d;
    logic                   csr_we_q, csr_we_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WORD_LENGTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_redirect_q, rsp_redirect_d;
    logic [WORD_LENGTH-1:0] rsp_pc_q, rsp_pc_d;
    logic                   rsp_illegal_q, rsp_illegal_d;

    logic                   ro_violation;
    logic                   wants_write;
    logic [WORD_LENGTH-1:0] rmw_value;

    // A CSR op writes unless it is a set/clear whose source register is x0,
    // which architecturally must behave as a pure read.
    assign wants_write = (op_q == OP_RW) || !src_is_x0_q;

`ifdef CSR_RO_CHECK_EN
    // Writes into the read-only CSR space are turned into an illegal response
    // that still returns the old value.
    assign ro_violation = (addr_q[11:10] == 2'b11) && wants_write;
`else
    assign ro_violation = 1'b0;
`endif

    // Read-modify-write data is formed from the live read port in the READ
    // cycle, at the same edge that captures the old value.
    always_comb begin
        case (op_q)
            OP_RW:   rmw_value = src_q;
            OP_RS:   rmw_value = csr_rdata | src_q;
            default: rmw_value = csr_rdata & ~src_q;
        endcase
    end

    // Next-state and next-output logic. All CSR port and response outputs are
    // registered, so each state prepares the values the following state must
    // present. The ECALL PC goes straight into the write-data register at
    // accept time, so no separate PC latch is kept.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        addr_d         = addr_q;
        src_d          = src_q;
        src_is_x0_d    = src_is_x0_q;
        old_d          = old_q;
        csr_addr_d     = csr_addr_q;
        csr_wdata_d    = csr_wdata_q;
        csr_we_d       = 1'b0;
        rsp_valid_d    = 1'b0;
        rsp_rdata_d    = '0;
        rsp_redirect_d = 1'b0;
        rsp_pc_d       = '0;
        rsp_illegal_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    addr_d      = req_addr;
                    src_d       = req_src;
                    src_is_x0_d = req_src_is_x0;
                    case (req_op)
                        OP_RW, OP_RS, OP_RC: begin
                            state_d    = ST_READ;
                            csr_addr_d = zext_addr(req_addr);
                        end
                        OP_ECALL: begin
                            state_d     = ST_EPC;
                            csr_addr_d  = zext_addr(MEPC_ADDR);
                            csr_wdata_d = req_pc;
                            csr_we_d    = 1'b1;
                        end
                        OP_MRET: begin
                            state_d    = ST_VEC;
                            csr_addr_d = zext_addr(MEPC_ADDR);
                        end
                        OP_NONE: begin
                            state_d     = ST_RESP;
                            rsp_valid_d = 1'b1;
                        end
                        default: begin
                            state_d       = ST_RESP;
                            rsp_valid_d   = 1'b1;
                            rsp_illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_READ: begin
                state_d    = ST_WRITE;
                old_d      = csr_rdata;
                csr_addr_d = zext_addr(addr_q);
                if (wants_write && !ro_violation) begin
                    csr_wdata_d = rmw_value;
                    csr_we_d    = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d       = ST_RESP;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = old_q;
                rsp_illegal_d = ro_violation;
            end
            ST_EPC: begin
                state_d     = ST_CAUSE;
                csr_addr_d  = zext_addr(MCAUSE_ADDR);
                csr_wdata_d = WORD_LENGTH'(ECALL_CAUSE);
                csr_we_d    = 1'b1;
            end
            ST_CAUSE: begin
                state_d    = ST_VEC;
                csr_addr_d = zext_addr(MTVEC_ADDR);
            end
            ST_VEC: begin
                state_d        = ST_RESP;
                rsp_valid_d    = 1'b1;
                rsp_redirect_d = 1'b1;
                rsp_pc_d       = csr_rdata;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any sequence in flight and
    // drops a pending write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_NONE;
            addr_q         <= '0;
            src_q          <= '0;
            src_is_x0_q    <= 1'b0;
            old_q          <= '0;
            csr_addr_q     <= '0;
            csr_wdata_q    <= '0;
            csr_we_q       <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_redirect_q <= 1'b0;
            rsp_pc_q       <= '0;
            rsp_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            addr_q         <= addr_d;
            src_q          <= src_d;
            src_is_x0_q    <= src_is_x0_d;
            old_q          <= old_d;
            csr_addr_q     <= csr_addr_d;
            csr_wdata_q    <= csr_wdata_d;
            csr_we_q       <= csr_we_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            rsp_redirect_q <= rsp_redirect_d;
            rsp_pc_q       <= rsp_pc_d;
            rsp_illegal_q  <= rsp_illegal_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign csr_addr     = csr_addr_q;
    assign csr_wdata    = csr_wdata_q;
    assign csr_we       = csr_we_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_redirect = rsp_redirect_q;
    assign rsp_pc       = rsp_pc_q;
    assign rsp_illegal  = rsp_illegal_q;

endmodule

// File: tb/tb_riscv_csr_access_unit.sv
// ---------------------------------------------------------------------------
// tb_riscv_csr_access_unit
//
// Self-checking bench for riscv_csr_access_unit. A small CSR file model
// (combinational read, synchronous write) is attached to the CSR port.
// CSR read-modify-write ops come from a table of directed vectors; ECALL,
// MRET, NONE/illegal ops and the reset cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_riscv_csr_access_unit;

    localparam int WL = 32;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [11:0]   req_addr;
    logic [WL-1:0] req_src;
    logic          req_src_is_x0;
    logic [WL-1:0] req_pc;
    logic [WL-1:0] csr_addr;
    logic [WL-1:0] csr_wdata;
    logic          csr_we;
    logic [WL-1:0] csr_rdata;
    logic          rsp_valid;
    logic [WL-1:0] rsp_rdata;
    logic          rsp_redirect;
    logic [WL-1:0] rsp_pc;
    logic          rsp_illegal;

    logic [WL-1:0] csr_mem [0:4095];
    logic          pl_en;
    logic [11:0]   pl_addr;
    logic [WL-1:0] pl_data;

    int checks;
    int errors;

    riscv_csr_access_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_src       (req_src),
        .req_src_is_x0 (req_src_is_x0),
        .req_pc        (req_pc),
        .csr_addr      (csr_addr),
        .csr_wdata     (csr_wdata),
        .csr_we        (csr_we),
        .csr_rdata     (csr_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_redirect  (rsp_redirect),
        .rsp_pc        (rsp_pc),
        .rsp_illegal   (rsp_illegal)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CSR file model: combinational read port, synchronous write port, plus a
    // bench-side preload path used to set up register contents between tests.
    assign csr_rdata = csr_mem[csr_addr[11:0]];

    always @(posedge clk) begin
        if (csr_we)
            csr_mem[csr_addr[11:0]] <= csr_wdata;
        else if (pl_en)
            csr_mem[pl_addr] <= pl_data;
    end

    typedef struct {
        logic [2:0]    op;
        logic [11:0]   addr;
        logic [WL-1:0] init;
        logic [WL-1:0] src;
        logic          x0;
        logic [WL-1:0] exp_rdata;
        int            exp_nwe;
        logic [WL-1:0] exp_wdata;
        logic          exp_ill;
        logic [WL-1:0] exp_final;
    } vec_t;

    vec_t vecs [7];

    // Compare one value and count it
    task automatic checkOutput(input string name, input logic [WL-1:0] act, input logic [WL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Load a CSR file location through the model's write port
    task automatic preload(input logic [11:0] a, input logic [WL-1:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    // Issue one request and observe the sequence up to the response pulse.
    // Latency counts clock edges after the accept edge; -1 means no response.
    task automatic applyStimulus(
        input  logic [2:0]    op,
        input  logic [11:0]   addr,
        input  logic [WL-1:0] src,
        input  logic          x0,
        input  logic [WL-1:0] pc,
        output int            lat,
        output int            nwe,
        output int            we_cyc0,
        output int            we_cyc1,
        output logic [WL-1:0] wa0,
        output logic [WL-1:0] wd0,
        output logic [WL-1:0] wa1,
        output logic [WL-1:0] wd1,
        output logic [WL-1:0] rdata,
        output logic [WL-1:0] rpc,
        output logic          redir,
        output logic          ill,
        output logic          post_ready,
        output logic          post_valid
    );
        lat = -1; nwe = 0; we_cyc0 = -1; we_cyc1 = -1;
        wa0 = '0; wd0 = '0; wa1 = '0; wd1 = '0;
        rdata = '0; rpc = '0; redir = 1'b0; ill = 1'b0;
        @(negedge clk);
        req_valid     = 1'b1;
        req_op        = op;
        req_addr      = addr;
        req_src       = src;
        req_src_is_x0 = x0;
        req_pc        = pc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (csr_we) begin
                if (nwe == 0) begin
                    wa0 = csr_addr; wd0 = csr_wdata; we_cyc0 = k;
                end else begin
                    wa1 = csr_addr; wd1 = csr_wdata; we_cyc1 = k;
                end
                nwe++;
            end
            if (rsp_valid) begin
                lat   = k;
                rdata = rsp_rdata;
                rpc   = rsp_pc;
                redir = rsp_redirect;
                ill   = rsp_illegal;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        post_ready = req_ready;
        post_valid = rsp_valid;
    endtask

    int            lat, nwe, wc0, wc1;
    logic [WL-1:0] wa0, wd0, wa1, wd1, rdata, rpc;
    logic          redir, ill, pready, pvalid;
    int            wd_cycles;

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_op        = 3'd0;
        req_addr      = '0;
        req_src       = '0;
        req_src_is_x0 = 1'b0;
        req_pc        = '0;
        pl_en         = 1'b0;
        pl_addr       = '0;
        pl_data       = '0;

        // RS/RC/RW vectors with hand-computed results
        vecs[0] = '{3'd2, 12'h300, 32'h0000_00F0, 32'h0000_000F, 1'b0, 32'h0000_00F0, 1, 32'h0000_00FF, 1'b0, 32'h0000_00FF};
        vecs[1] = '{3'd3, 12'h300, 32'h0000_00FF, 32'h0000_000F, 1'b0, 32'h0000_00FF, 1, 32'h0000_00F0, 1'b0, 32'h0000_00F0};
        vecs[2] = '{3'd3, 12'h300, 32'h0000_00FF, 32'h0000_000F, 1'b1, 32'h0000_00FF, 0, 32'h0000_0000, 1'b0, 32'h0000_00FF};
        vecs[3] = '{3'd1, 12'h340, 32'h1234_5678, 32'hA5A5_0000, 1'b0, 32'h1234_5678, 1, 32'hA5A5_0000, 1'b0, 32'hA5A5_0000};
        vecs[4] = '{3'd2, 12'h340, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 0, 32'h0000_0000, 1'b0, 32'h0000_0000};
`ifdef CSR_RO_CHECK_EN
        vecs[5] = '{3'd1, 12'hC00, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF, 0, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
`else
        vecs[5] = '{3'd1, 12'hC00, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF, 1, 32'h0000_0001, 1'b0, 32'h0000_0001};
`endif
        vecs[6] = '{3'd2, 12'hC01, 32'h0000_0055, 32'h0000_0000, 1'b1, 32'h0000_0055, 0, 32'h0000_0000, 1'b0, 32'h0000_0055};

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_csr_we", 32'(csr_we), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_csr_addr", csr_addr, 32'd0);
        checkOutput("reset_rsp_pc", rsp_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_ready", 32'(req_ready), 32'd1);

        // Table-driven CSR read-modify-write ops
        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].addr, vecs[i].init);
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].x0, 32'h0,
                          lat, nwe, wc0, wc1, wa0, wd0, wa1, wd1, rdata, rpc, redir, ill, pready, pvalid);
            $display("[TB] vector %0d op=%0d addr=%h", i, vecs[i].op, vecs[i].addr);
            checkOutput("csr_latency", 32'(lat), 32'd3);
            checkOutput("csr_rsp_rdata", rdata, vecs[i].exp_rdata);
            checkOutput("csr_num_writes", 32'(nwe), 32'(vecs[i].exp_nwe));
            if (vecs[i].exp_nwe > 0) begin
                checkOutput("csr_write_cycle", 32'(wc0), 32'd2);
                checkOutput("csr_write_addr", wa0, {20'h0, vecs[i].addr});
                checkOutput("csr_write_data", wd0, vecs[i].exp_wdata);
            end
            checkOutput("csr_rsp_illegal", 32'(ill), 32'(vecs[i].exp_ill));
            checkOutput("csr_rsp_redirect", 32'(redir), 32'd0);
            checkOutput("csr_final_value", csr_mem[vecs[i].addr], vecs[i].exp_final);
            checkOutput("csr_post_ready", 32'(pready), 32'd1);
            checkOutput("csr_post_valid", 32'(pvalid), 32'd0);
        end

        // ECALL: mepc then mcause on consecutive cycles, redirect to mtvec
        preload(12'h305, 32'h0000_0100);
        applyStimulus(3'd4, 12'h000, 32'h0, 1'b0, 32'h0000_0040,
                      lat, nwe, wc0, wc1, wa0, wd0, wa1, wd1, rdata, rpc, redir, ill, pready, pvalid);
        checkOutput("ecall_latency", 32'(lat), 32'd4);
        checkOutput("ecall_num_writes", 32'(nwe), 32'd2);
        checkOutput("ecall_mepc_addr", wa0, 32'h0000_0341);
        checkOutput("ecall_mepc_data", wd0, 32'h0000_0040);
        checkOutput("ecall_mepc_cycle", 32'(wc0), 32'd1);
        checkOutput("ecall_mcause_addr", wa1, 32'h0000_0342);
        checkOutput("ecall_mcause_data", wd1, 32'd11);
        checkOutput("ecall_mcause_cycle", 32'(wc1), 32'd2);
        checkOutput("ecall_redirect", 32'(redir), 32'd1);
        checkOutput("ecall_rsp_pc", rpc, 32'h0000_0100);
        checkOutput("ecall_rsp_rdata", rdata, 32'd0);
        checkOutput("ecall_mepc_stored", csr_mem[12'h341], 32'h0000_0040);

        // MRET: read mepc, no writes
        preload(12'h341, 32'h0000_0044);
        applyStimulus(3'd5, 12'h000, 32'h0, 1'b0, 32'h0000_0080,
                      lat, nwe, wc0, wc1, wa0, wd0, wa1, wd1, rdata, rpc, redir, ill, pready, pvalid);
        checkOutput("mret_latency", 32'(lat), 32'd2);
        checkOutput("mret_num_writes", 32'(nwe), 32'd0);
        checkOutput("mret_redirect", 32'(redir), 32'd1);
        checkOutput("mret_rsp_pc", rpc, 32'h0000_0044);

        // Illegal opcode and NONE go straight to the response
        applyStimulus(3'd7, 12'h300, 32'h1, 1'b0, 32'h0,
                      lat, nwe, wc0, wc1, wa0, wd0, wa1, wd1, rdata, rpc, redir, ill, pready, pvalid);
        checkOutput("illegal_latency", 32'(lat), 32'd1);
        checkOutput("illegal_flag", 32'(ill), 32'd1);
        checkOutput("illegal_num_writes", 32'(nwe), 32'd0);
        checkOutput("illegal_redirect", 32'(redir), 32'd0);
        applyStimulus(3'd0, 12'h300, 32'h1, 1'b0, 32'h0,
                      lat, nwe, wc0, wc1, wa0, wd0, wa1, wd1, rdata, rpc, redir, ill, pready, pvalid);
        checkOutput("none_latency", 32'(lat), 32'd1);
        checkOutput("none_illegal", 32'(ill), 32'd0);
        checkOutput("none_num_writes", 32'(nwe), 32'd0);

        // Reset in the WRITE cycle drops the strobe at once, no write lands
        preload(12'h300, 32'h0000_1111);
        @(negedge clk);
        req_valid     = 1'b1;
        req_op        = 3'd1;
        req_addr      = 12'h300;
        req_src       = 32'h0000_2222;
        req_src_is_x0 = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wd_cycles = 0;
        while (!csr_we && wd_cycles < 6) begin
            @(posedge clk);
            #1;
            wd_cycles++;
        end
        checkOutput("abort_saw_write_strobe", 32'(csr_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_we_dropped", 32'(csr_we), 32'd0);
        checkOutput("abort_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("abort_no_write", csr_mem[12'h300], 32'h0000_1111);
        checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
